// File: rtl/rv_alu_mc_pkg.sv
// Shared types and constants for the multi-cycle integer execute unit.
//   alu_func_e     : RISC-V funct3 encodings for all reg-imm / reg-reg ALU ops
//   alu_state_e    : execute-unit control states
//   FUNCT7_ALT_BIT : instruction bit that carries the SUB/SRA alternate select
package rv_alu_mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_func_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  localparam int unsigned FUNCT7_ALT_BIT = 30;

endpackage

// File: rtl/rv_iter_shifter.sv
// Iterative shifter: moves a working register by up to SHIFT_STEP bit
// positions per cycle until the remaining count reaches zero.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operand/shamt/direction (one cycle)
//   dir      : 0 = left, 1 = right
//   arith    : right shifts replicate the sign bit when set
//   operand  : value to shift
//   shamt    : total shift distance
//   done     : this cycle's step finishes the shift (stays high at count 0)
//   out      : working register after this cycle's step
module rv_iter_shifter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dir,
  input  logic                     arith,
  input  logic [XLEN-1:0]          operand,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     done,
  output logic [XLEN-1:0]          out
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is representable.
  localparam int unsigned AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP = AMT_W'(SHIFT_STEP);

  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;
  logic [AMT_W-1:0]   amt;

  // out is the post-step value, so the owner can capture the result on the
  // same edge that retires the final step. At count 0 the step is zero and
  // the register simply holds.
  always_comb begin
    done = ({1'b0, cnt_q} <= STEP);
    amt  = done ? {1'b0, cnt_q} : STEP;
    if (dir_q) begin
      if (arith_q) out = $signed(work_q) >>> amt;
      else         out = work_q >> amt;
    end else begin
      out = work_q << amt;
    end
  end

  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (start) begin
      work_d  = operand;
      cnt_d   = shamt;
      dir_d   = dir;
      arith_d = arith;
    end else begin
      work_d = out;
      // amt never exceeds cnt_q, so the narrowing is lossless.
      cnt_d  = cnt_q - SHAMT_W'(amt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/rv_alu_mc.sv
// Multi-cycle RV32I/RV64I integer execute unit.
// Single-cycle ops (ADD/SUB, SLT/SLTU, XOR/OR/AND, zero-distance shifts)
// are registered with latency 1; non-zero shifts go through rv_iter_shifter.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation handshake from decode/register-read
//   funct3, alt, src_sel : op select, bit-30 alternate, B = rs2 (1) / imm (0)
//   rs1_val, rs2_val, imm: operands
//   rd_addr              : destination tag, passed through
//   out_valid / out_ready: result handshake to writeback
//   result, out_rd       : registered result and its tag
//   busy                 : iterative shift in progress
module rv_alu_mc
  import rv_alu_mc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            src_sel,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            busy_q, busy_d;

  alu_func_e       func;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic            is_shift;
  logic            slot_free;
  logic            accept;
  logic            sh_start;
  logic            sh_dir;
  logic            sh_arith;
  logic            sh_done;
  logic [XLEN-1:0] sh_out;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_rd    = out_rd_q;
  assign busy      = busy_q;

  always_comb begin
    func     = alu_func_e'(funct3);
    op_b     = src_sel ? rs2_val : imm;
    shamt    = op_b[SHAMT_W-1:0];
    is_shift = (func == ALU_SLL) || (func == ALU_SRL);
    sh_dir   = (func == ALU_SRL);
    sh_arith = alt && (func == ALU_SRL);
    alu_res  = '0;
    case (func)
      // alt only means SUB for the register-register form.
      ALU_ADD:  alu_res = (src_sel && alt) ? rs1_val - op_b : rs1_val + op_b;
      ALU_SLT:  alu_res = XLEN'($signed(rs1_val) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(rs1_val < op_b);
      ALU_XOR:  alu_res = rs1_val ^ op_b;
      ALU_OR:   alu_res = rs1_val | op_b;
      ALU_AND:  alu_res = rs1_val & op_b;
      // Shifts only complete here when shamt is zero.
      default:  alu_res = rs1_val;
    endcase
  end

  rv_iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .dir     (sh_dir),
    .arith   (sh_arith),
    .operand (rs1_val),
    .shamt   (shamt),
    .done    (sh_done),
    .out     (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_rd_d    = out_rd_q;
    pend_rd_d   = pend_rd_q;
    sh_start    = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_start  = 1'b1;
            pend_rd_d = rd_addr;
            state_d   = ST_SHIFT;
          end else begin
            result_d    = alu_res;
            out_rd_d    = rd_addr;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // A finished shift waits here (count parked at 0) until the slot
        // is empty or draining this cycle.
        if (sh_done && slot_free) begin
          result_d    = sh_out;
          out_rd_d    = pend_rd_q;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
      pend_rd_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_rd_q    <= out_rd_d;
      pend_rd_q   <= pend_rd_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_rv_alu_mc.sv
// Scoreboard bench for rv_alu_mc: three instances (XLEN/STEP = 32/1, 32/8,
// 64/16) driven from tasks; a negedge monitor pops expectations and checks
// result, tag, latency and hold stability.
module tb_rv_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
    bit          exact;
  } exp_t;

  exp_t exp_q[3][$];

  logic [2:0]  in_valid_v, in_ready_v, alt_v, src_sel_v, out_valid_v, busy_v;
  logic [2:0]  out_ready_v = '1;
  logic [2:0]  funct3_v [3];
  logic [63:0] rs1_v [3];
  logic [63:0] rs2_v [3];
  logic [63:0] imm_v [3];
  logic [4:0]  rd_v [3];
  logic [31:0] res_a, res_b;
  logic [63:0] res_c;
  logic [4:0]  ord_a, ord_b, ord_c;
  logic [63:0] res_v [3];
  logic [4:0]  ord_v [3];

  always_comb begin
    res_v[0] = {32'b0, res_a};
    res_v[1] = {32'b0, res_b};
    res_v[2] = res_c;
    ord_v[0] = ord_a;
    ord_v[1] = ord_b;
    ord_v[2] = ord_c;
  end

  bit hold [3];
  bit bp_rand [3];
  int tag [3];
  int busy_cnt [3];
  int drain_cyc_by_rd [32];

  rv_alu_mc #(.XLEN(32), .SHIFT_STEP(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .funct3(funct3_v[0]), .alt(alt_v[0]), .src_sel(src_sel_v[0]),
    .rs1_val(rs1_v[0][31:0]), .rs2_val(rs2_v[0][31:0]), .imm(imm_v[0][31:0]),
    .rd_addr(rd_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .result(res_a), .out_rd(ord_a), .busy(busy_v[0]));

  rv_alu_mc #(.XLEN(32), .SHIFT_STEP(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .funct3(funct3_v[1]), .alt(alt_v[1]), .src_sel(src_sel_v[1]),
    .rs1_val(rs1_v[1][31:0]), .rs2_val(rs2_v[1][31:0]), .imm(imm_v[1][31:0]),
    .rd_addr(rd_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .result(res_b), .out_rd(ord_b), .busy(busy_v[1]));

  rv_alu_mc #(.XLEN(64), .SHIFT_STEP(16)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .funct3(funct3_v[2]), .alt(alt_v[2]), .src_sel(src_sel_v[2]),
    .rs1_val(rs1_v[2]), .rs2_val(rs2_v[2]), .imm(imm_v[2]),
    .rd_addr(rd_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .result(res_c), .out_rd(ord_c), .busy(busy_v[2]));

  function automatic int xlen_of(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 8 : 16);
  endfunction

  // Reference semantics: plain modular arithmetic on 64-bit values.
  function automatic logic [63:0] ref_alu(input int xl, input logic [2:0] f3,
      input logic a_alt, input logic sel, input logic [63:0] a_in,
      input logic [63:0] b2, input logic [63:0] im);
    logic [63:0] mask, a, b, r;
    longint sa, sb;
    int sh;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    b = (sel ? b2 : im) & mask;
    sh = int'(b % 64'(xl));
    if (xl == 64) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
    end
    case (f3)
      3'd0: r = (sel && a_alt) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: r = a_alt ? 64'(sa >>> sh) : (a >> sh);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r & mask;
  endfunction

  function automatic int exp_lat(input int d, input logic [2:0] f3,
      input logic sel, input logic [63:0] b2, input logic [63:0] im);
    logic [63:0] b;
    int sh, st;
    b  = sel ? b2 : im;
    sh = int'(b % 64'(xlen_of(d)));
    st = step_of(d);
    if ((f3 == 3'd1 || f3 == 3'd5) && sh > 0) return 1 + (sh + st - 1) / st;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Drives one op and waits for acceptance; leaves in_valid high so a
  // following send() issues back-to-back. Call idle() to stop offering.
  task automatic send(input int d, input logic [2:0] f3, input logic a_alt,
      input logic sel, input logic [63:0] a, input logic [63:0] b2,
      input logic [63:0] im, input bit exact, input bit has_exp,
      input logic [63:0] exp_val, input bit push, output int acc);
    exp_t e;
    int n;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b1;
    funct3_v[d]   = f3;
    alt_v[d]      = a_alt;
    src_sel_v[d]  = sel;
    rs1_v[d]      = a;
    rs2_v[d]      = b2;
    imm_v[d]      = im;
    rd_v[d]       = 5'(tag[d]);
    tag[d]        = (tag[d] + 1) % 32;
    acc = -1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready_v[d]) break;
    end
    if (n == 300) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d: in_ready got 0 expected 1", d);
      in_valid_v[d] = 1'b0;
    end else begin
      acc     = cyc;
      e.res   = has_exp ? exp_val : ref_alu(xlen_of(d), f3, a_alt, sel, a, b2, im);
      e.rd    = rd_v[d];
      e.acc   = cyc;
      e.lat   = exp_lat(d, f3, sel, b2, im);
      e.exact = exact;
      if (push) exp_q[d].push_back(e);
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
  endtask

  task automatic wait_empty(input int d);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q[d].size() == 0 && !out_valid_v[d]) break;
    end
    if (n == 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout dut%0d: pending got %0d expected 0", d, exp_q[d].size());
    end
  endtask

  task automatic rand_run(input int d, input int n);
    int acc;
    logic [63:0] a, b2, im;
    bp_rand[d] = 1'b1;
    repeat (n) begin
      a  = {$urandom, $urandom};
      b2 = {$urandom, $urandom};
      im = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom), 1'b1, 31'($urandom)};
      if ($urandom_range(0, 5) == 0) b2 = a;
      send(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), a, b2, im, 1'b0, 1'b0, '0, 1'b1, acc);
      if ($urandom_range(0, 3) == 0) idle(d);
    end
    idle(d);
    bp_rand[d] = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++)
      out_ready_v[d] = hold[d] ? 1'b0 : (bp_rand[d] ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  logic [63:0] prev_res [3];
  logic [4:0]  prev_rd [3];
  bit          prev_hold [3];
  int          first_cyc [3];
  exp_t        mon_e;
  int          lat_act;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        prev_hold[d] = 1'b0;
      end else begin
        if (out_valid_v[d]) begin
          if (prev_hold[d]) begin
            chk($sformatf("hold_result_dut%0d", d), res_v[d], prev_res[d]);
            chk($sformatf("hold_rd_dut%0d", d), 64'(ord_v[d]), 64'(prev_rd[d]));
          end else begin
            first_cyc[d] = cyc;
          end
          if (out_ready_v[d]) begin
            if (exp_q[d].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output dut%0d: got 0x%0h expected no result", d, res_v[d]);
            end else begin
              mon_e = exp_q[d].pop_front();
              chk($sformatf("result_dut%0d", d), res_v[d], mon_e.res);
              chk($sformatf("out_rd_dut%0d", d), 64'(ord_v[d]), 64'(mon_e.rd));
              lat_act = first_cyc[d] - mon_e.acc;
              if (mon_e.exact) begin
                chk($sformatf("latency_dut%0d", d), 64'(lat_act), 64'(mon_e.lat));
              end else begin
                checks++;
                if (lat_act < mon_e.lat) begin
                  failures++;
                  $display("FAIL min_latency_dut%0d: got %0d expected >= %0d", d, lat_act, mon_e.lat);
                end
              end
              if (d == 0) drain_cyc_by_rd[ord_v[0]] = cyc;
            end
          end
        end
        prev_hold[d] = out_valid_v[d] && !out_ready_v[d];
      end
      if (busy_v[d]) busy_cnt[d]++;
      prev_res[d] = res_v[d];
      prev_rd[d]  = ord_v[d];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  int acc, acc_prev, rd1;

  initial begin
    rst = 1'b1;
    in_valid_v = '0;
    alt_v = '0;
    src_sel_v = '0;
    for (int d = 0; d < 3; d++) begin
      funct3_v[d] = '0; rs1_v[d] = '0; rs2_v[d] = '0; imm_v[d] = '0; rd_v[d] = '0;
      hold[d] = 1'b0; bp_rand[d] = 1'b0; tag[d] = 0; busy_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid_dut%0d", d), 64'(out_valid_v[d]), 64'd0);
      chk($sformatf("rst_result_dut%0d", d), res_v[d], 64'd0);
      chk($sformatf("rst_out_rd_dut%0d", d), 64'(ord_v[d]), 64'd0);
      chk($sformatf("rst_busy_dut%0d", d), 64'(busy_v[d]), 64'd0);
      chk($sformatf("rst_in_ready_dut%0d", d), 64'(in_ready_v[d]), 64'd1);
    end

    // Directed: 32-bit, step 1
    send(0, 3'd0, 1'b0, 1'b0, 64'h7FFF_FFFF, 64'd0, 64'd1, 1'b1, 1'b1, 64'h8000_0000, 1'b1, acc);
    send(0, 3'd0, 1'b1, 1'b1, 64'd5, 64'd7, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b1, acc);
    send(0, 3'd0, 1'b1, 1'b0, 64'd5, 64'd0, 64'd7, 1'b1, 1'b1, 64'd12, 1'b1, acc);
    send(0, 3'd2, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 64'd1, 1'b1, acc);
    send(0, 3'd3, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, acc);
    send(0, 3'd3, 1'b0, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF, 1'b1, 1'b1, 64'd1, 1'b1, acc);
    send(0, 3'd1, 1'b0, 1'b0, 64'h1234, 64'd0, 64'h20, 1'b1, 1'b1, 64'h1234, 1'b1, acc);
    idle(0);
    wait_empty(0);
    send(0, 3'd5, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'd31, 1'b1, 1'b1, 64'hFFFF_FFFF, 1'b1, acc);
    busy_cnt[0] = 0;
    idle(0);
    wait_empty(0);
    chk("srai_busy_cycles", 64'(busy_cnt[0]), 64'd31);
    send(0, 3'd5, 1'b0, 1'b0, 64'h8000_0000, 64'd0, 64'd31, 1'b1, 1'b1, 64'h1, 1'b1, acc);
    idle(0);
    wait_empty(0);

    // Directed: 32-bit step 8, 64-bit step 16
    send(1, 3'd1, 1'b0, 1'b1, 64'd1, 64'hFFFF_FF23, 64'd0, 1'b1, 1'b1, 64'h8, 1'b1, acc);
    send(1, 3'd5, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'h1F, 1'b1, 1'b1, 64'hFFFF_FFFF, 1'b1, acc);
    idle(1);
    wait_empty(1);
    send(2, 3'd5, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b1, 1'b1, 64'd1, 1'b1, acc);
    send(2, 3'd5, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
    send(2, 3'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, acc);
    idle(2);
    wait_empty(2);

    // Backpressure, drain+accept in one cycle, then a 10-op stream
    hold[0] = 1'b1;
    rd1 = tag[0];
    send(0, 3'd0, 1'b0, 1'b1, 64'd100, 64'd23, 64'd0, 1'b1, 1'b1, 64'd123, 1'b1, acc);
    fork
      send(0, 3'd0, 1'b0, 1'b0, 64'd40, 64'd0, 64'd2, 1'b1, 1'b1, 64'd42, 1'b1, acc_prev);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
          chk("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
        end
        hold[0] = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      send(0, 3'd0, 1'b0, 1'b1, 64'($urandom), 64'($urandom), 64'd0, 1'b1, 1'b0, '0, 1'b1, acc);
      chk("stream_accept_cycle", 64'(acc), 64'(acc_prev + 1));
      acc_prev = acc;
    end
    idle(0);
    wait_empty(0);
    chk("drain_accept_same_cycle", 64'(drain_cyc_by_rd[rd1]), 64'(acc_prev - 10));

    // Randomised traffic with random backpressure on all instances
    fork
      rand_run(0, 120);
      rand_run(1, 80);
      rand_run(2, 80);
    join
    for (int d = 0; d < 3; d++) wait_empty(d);

    // Reset in the third cycle of a 20-cycle SRL: nothing may be emitted
    send(0, 3'd5, 1'b0, 1'b0, 64'hDEAD_BEEF, 64'd0, 64'd19, 1'b1, 1'b0, '0, 1'b0, acc);
    idle(0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("post_rst_busy", 64'(busy_v[0]), 64'd0);
    repeat (25) @(negedge clk);
    chk("post_rst_no_stale", 64'(out_valid_v[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
